// File: rtl/reset_pkg.sv
// Shared types for the reset sequencer: reset-cause encoding, FSM states and
// a width helper for the sequencer's counters.
package reset_pkg;

    typedef enum logic [1:0] {
        POR  = 2'b00,
        SOFT = 2'b01,
        WDT  = 2'b10
    } rst_cause_t;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RELEASE = 2'b01,
        RUN     = 2'b10
    } rst_seq_state_t;

    // Counter width for a terminal value of v-1; a zero-width register is not legal.
    function automatic int clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Request/status bundle between the reset sequencer and the logic that
// requests resets and consumes the per-domain reset outputs.
interface reset_seq_if #(
    parameter int N_DOM = 3
);
    logic             i_soft_rst_req;
    logic             i_wdt_expire;
    logic [N_DOM-1:0] o_rst_dom;
    logic             o_rst_done;
    logic [1:0]       o_rst_cause;

    modport master (
        output i_soft_rst_req,
        output i_wdt_expire,
        input  o_rst_dom,
        input  o_rst_done,
        input  o_rst_cause
    );

    modport slave (
        input  i_soft_rst_req,
        input  i_wdt_expire,
        output o_rst_dom,
        output o_rst_done,
        output o_rst_cause
    );
endinterface

// File: rtl/reset_seq.sv
// Reset sequencer: holds all downstream reset domains for HOLD_CYCLES, then
// releases them one by one in index order, GAP_CYCLES apart.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   HOLD    | all domains asserted, counting the minimum hold width
//   RELEASE | domains 0..idx-1 released, counting the gap before domain idx
//   RUN     | all domains released, done set, counter idle
module reset_seq
    import reset_pkg::*;
#(
    parameter int N_DOM       = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        arst,
    reset_seq_if.slave  bus
);

    localparam int CNT_W = clog2_min1((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
    localparam int IDX_W = clog2_min1(N_DOM);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    rst_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N_DOM-1:0] dom_q, dom_d;
    logic             done_q, done_d;
    rst_cause_t       cause_q, cause_d;

    logic req;
    logic hold_end;
    logic gap_end;

    assign req      = bus.i_soft_rst_req | bus.i_wdt_expire;
    assign hold_end = (cnt_q == HOLD_LAST);
    assign gap_end  = (cnt_q == GAP_LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // A request from any state restarts the whole sequence from HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (req) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_end) begin
                        cnt_d = '0;
                        if (N_DOM == 1) begin
                            state_d = RUN;
                        end else begin
                            state_d = RELEASE;
                            idx_d   = IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_end) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs; outputs never see inputs combinationally.
    always_comb begin
        dom_d   = dom_q;
        done_d  = done_q;
        cause_d = cause_q;
        if (req) begin
            dom_d   = '1;
            done_d  = 1'b0;
            cause_d = bus.i_wdt_expire ? WDT : SOFT;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_end) begin
                        dom_d[0] = 1'b0;
                        if (N_DOM == 1) begin
                            done_d = 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (gap_end) begin
                        dom_d[idx_q] = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    dom_d = dom_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dom_q   <= '1;
            done_q  <= 1'b0;
            cause_q <= POR;
        end else begin
            dom_q   <= dom_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    assign bus.o_rst_dom   = dom_q;
    assign bus.o_rst_done  = done_q;
    assign bus.o_rst_cause = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: a 3-domain 16/8 instance and a 1-domain 1/1
// instance share clock and arst; expected values are hand-derived edge counts.
module tb_reset_seq;

    logic clk;
    logic arst;

    int n_checks = 0;
    int n_errors = 0;

    reset_seq_if #(.N_DOM(3)) if_a ();
    reset_seq_if #(.N_DOM(1)) if_b ();

    reset_seq #(
        .N_DOM(3), .HOLD_CYCLES(16), .GAP_CYCLES(8)
    ) dut_a (
        .clk (clk),
        .arst(arst),
        .bus (if_a)
    );

    reset_seq #(
        .N_DOM(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)
    ) dut_b (
        .clk (clk),
        .arst(arst),
        .bus (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_a(input string tag, input logic [2:0] dom, input logic done,
                           input logic [1:0] cause);
        check({tag, "_dom"},   32'(if_a.o_rst_dom),   32'(dom));
        check({tag, "_done"},  32'(if_a.o_rst_done),  32'(done));
        check({tag, "_cause"}, 32'(if_a.o_rst_cause), 32'(cause));
    endtask

    task automatic check_b(input string tag, input logic dom, input logic done,
                           input logic [1:0] cause);
        check({tag, "_dom"},   32'(if_b.o_rst_dom),   32'(dom));
        check({tag, "_done"},  32'(if_b.o_rst_done),  32'(done));
        check({tag, "_cause"}, 32'(if_b.o_rst_cause), 32'(cause));
    endtask

    initial begin
        arst = 1'b1;
        if_a.i_soft_rst_req = 1'b0;
        if_a.i_wdt_expire   = 1'b0;
        if_b.i_soft_rst_req = 1'b0;
        if_b.i_wdt_expire   = 1'b0;

        // power-on reset
        #12;
        check_a("por_hold_a", 3'b111, 1'b0, 2'b00);
        check_b("por_hold_b", 1'b1, 1'b0, 2'b00);
        tick();
        arst = 1'b0;

        tick();
        check_b("por_e1_b", 1'b0, 1'b1, 2'b00);
        check_a("por_e1_a", 3'b111, 1'b0, 2'b00);
        tick_n(14);
        check_a("por_e15", 3'b111, 1'b0, 2'b00);
        tick();
        check_a("por_e16", 3'b110, 1'b0, 2'b00);
        tick_n(7);
        check_a("por_e23", 3'b110, 1'b0, 2'b00);
        tick();
        check_a("por_e24", 3'b100, 1'b0, 2'b00);
        tick_n(7);
        check_a("por_e31", 3'b100, 1'b0, 2'b00);
        tick();
        check_a("por_e32", 3'b000, 1'b1, 2'b00);
        tick_n(5);
        check_a("por_run", 3'b000, 1'b1, 2'b00);

        // soft request in RUN
        if_a.i_soft_rst_req = 1'b1;
        tick();
        if_a.i_soft_rst_req = 1'b0;
        check_a("soft_e0", 3'b111, 1'b0, 2'b01);
        tick_n(15);
        check_a("soft_e15", 3'b111, 1'b0, 2'b01);
        tick();
        check_a("soft_e16", 3'b110, 1'b0, 2'b01);
        tick_n(8);
        check_a("soft_e24", 3'b100, 1'b0, 2'b01);
        tick_n(8);
        check_a("soft_e32", 3'b000, 1'b1, 2'b01);

        // simultaneous soft + watchdog: watchdog wins
        if_a.i_soft_rst_req = 1'b1;
        if_a.i_wdt_expire   = 1'b1;
        tick();
        if_a.i_soft_rst_req = 1'b0;
        if_a.i_wdt_expire   = 1'b0;
        check_a("both_e0", 3'b111, 1'b0, 2'b10);
        tick_n(16);
        check_a("both_e16", 3'b110, 1'b0, 2'b10);
        tick_n(8);
        check_a("both_e24", 3'b100, 1'b0, 2'b10);
        tick_n(8);
        check_a("both_e32", 3'b000, 1'b1, 2'b10);

        // soft then watchdog 20 edges later, after bit 0 released
        if_a.i_soft_rst_req = 1'b1;
        tick();
        if_a.i_soft_rst_req = 1'b0;
        check_a("sw_e0", 3'b111, 1'b0, 2'b01);
        tick_n(19);
        check_a("sw_e19", 3'b110, 1'b0, 2'b01);
        if_a.i_wdt_expire = 1'b1;
        tick();
        if_a.i_wdt_expire = 1'b0;
        check_a("sw_e20", 3'b111, 1'b0, 2'b10);
        tick_n(15);
        check_a("sw_e35", 3'b111, 1'b0, 2'b10);
        tick();
        check_a("sw_e36", 3'b110, 1'b0, 2'b10);
        tick_n(8);
        check_a("sw_e44", 3'b100, 1'b0, 2'b10);
        tick_n(8);
        check_a("sw_e52", 3'b000, 1'b1, 2'b10);

        // requests on consecutive edges: timeline restarts at the second one
        if_a.i_soft_rst_req = 1'b1;
        tick();
        tick();
        if_a.i_soft_rst_req = 1'b0;
        tick_n(15);
        check_a("consec_e16", 3'b111, 1'b0, 2'b01);
        tick();
        check_a("consec_e17", 3'b110, 1'b0, 2'b01);
        tick_n(16);
        check_a("consec_e33", 3'b000, 1'b1, 2'b01);

        // async arst in the middle of a soft sequence
        if_a.i_soft_rst_req = 1'b1;
        tick();
        if_a.i_soft_rst_req = 1'b0;
        tick_n(27);
        check_a("mid_e27", 3'b100, 1'b0, 2'b01);
        #3;
        arst = 1'b1;
        #1;
        check_a("mid_arst", 3'b111, 1'b0, 2'b00);
        check_b("mid_arst_b", 1'b1, 1'b0, 2'b00);
        tick();
        arst = 1'b0;
        tick();
        check_b("rearst_e1_b", 1'b0, 1'b1, 2'b00);
        tick_n(14);
        check_a("rearst_e15", 3'b111, 1'b0, 2'b00);
        tick();
        check_a("rearst_e16", 3'b110, 1'b0, 2'b00);
        tick_n(8);
        check_a("rearst_e24", 3'b100, 1'b0, 2'b00);
        tick_n(8);
        check_a("rearst_e32", 3'b000, 1'b1, 2'b00);

        // single-domain instance, HOLD=GAP=1
        if_b.i_soft_rst_req = 1'b1;
        tick();
        if_b.i_soft_rst_req = 1'b0;
        check_b("one_soft_e0", 1'b1, 1'b0, 2'b01);
        tick();
        check_b("one_soft_e1", 1'b0, 1'b1, 2'b01);
        if_b.i_wdt_expire = 1'b1;
        tick();
        if_b.i_wdt_expire = 1'b0;
        check_b("one_wdt_e0", 1'b1, 1'b0, 2'b10);
        tick();
        check_b("one_wdt_e1", 1'b0, 1'b1, 2'b10);
        check_a("a_undisturbed", 3'b000, 1'b1, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
# reset_seq

Reset sequencer for the chip's reset tree. It consumes the already-synchronized global reset plus software and watchdog reset requests. It holds every downstream reset domain for a minimum width, then releases the domains one at a time in a fixed order with a programmable gap. It also reports completion and the cause of the last reset. It sits between the top-level reset synchronizer and the per-subsystem reset inputs (core, memory, peripherals).

## Interface
- `N_DOM`, 3 — number of sequenced reset domains, ≥1; bit 0 is released first.
- `HOLD_CYCLES`, 16 — minimum assertion width of all domains, ≥1.
- `GAP_CYCLES`, 8 — cycles between successive domain releases, ≥1.

- `clk`  in  1  — single clock.
- `arst`  in  1  — asynchronous, active-high reset; deassertion already synchronous to `clk`.
- `i_soft_rst_req`  in  1  — software reset request; single-cycle pulse, sampled on `clk`.
- `i_wdt_expire`  in  1  — watchdog expiry; single-cycle pulse, sampled on `clk`.
- `o_rst_dom`  out  N_DOM  — per-domain reset, active-high.
- `o_rst_done`  out  1  — high when all domains are released.
- `o_rst_cause`  out  2  — cause of the last reset: 00 = arst/power-on, 01 = soft, 10 = watchdog, 11 = never produced.

## Operation
- FSM states: HOLD, RELEASE, RUN. A counter `cnt` (width $clog2(max(HOLD_CYCLES,GAP_CYCLES)), min 1) and a domain index `idx` are kept.
- On `arst` (async):
  - state = HOLD, `cnt` = 0, `idx` = 0.
  - `o_rst_dom` = all ones, `o_rst_done` = 0, `o_rst_cause` = 00.
- HOLD:
  - `cnt` increments each cycle.
  - At `cnt` == HOLD_CYCLES−1, the next edge clears `o_rst_dom[0]` and sets `cnt` = 0.
  - If N_DOM == 1: go to RUN and set `o_rst_done`. Otherwise: go to RELEASE with `idx` = 1.
- RELEASE:
  - `cnt` increments each cycle.
  - At `cnt` == GAP_CYCLES−1, the next edge clears `o_rst_dom[idx]` and sets `cnt` = 0.
  - If `idx` == N_DOM−1: go to RUN and set `o_rst_done` on the same edge. Otherwise: `idx`++.
- RUN: outputs are stable and the counter is idle.
- Reset request (any state), when `i_soft_rst_req` or `i_wdt_expire` is sampled high:
  - Next edge: `o_rst_dom` = all ones, `o_rst_done` = 0.
  - Next edge: state = HOLD, `cnt` = 0, `idx` = 0.
  - Next edge: `o_rst_cause` = 10 if `i_wdt_expire`, else 01.
  - A request during HOLD or RELEASE restarts the whole sequence; already-released domains re-assert.
- Simultaneous soft and watchdog requests: watchdog wins (cause 10).
- `o_rst_dom` bits only ever transition 1→0 in index order, or all to 1 together. There is never a partial re-assert.
- `o_rst_cause` is sticky through RUN. It is only changed by `arst` or a new request.
- All outputs come straight from flops, with no combinational paths from inputs.

## Timing
- Let edge 0 be the `arst` deassertion (the first rising edge with `arst` low is edge 1), or the edge that samples a request.
- Bit k of `o_rst_dom` falls at edge HOLD_CYCLES + k·GAP_CYCLES.
- `o_rst_done` rises at edge HOLD_CYCLES + (N_DOM−1)·GAP_CYCLES, together with the last bit.
- Request-to-reassert latency: 1 edge.
- `arst` assertion takes effect immediately (asynchronous). Assertion mid-sequence or mid-request overrides everything.
- Requests arriving on consecutive cycles: each one restarts the timeline from its own sampling edge.

## Structure
- Shared package `reset_pkg`:
  - `rst_cause_t` enum (POR = 2'b00, SOFT = 2'b01, WDT = 2'b10).
  - `rst_seq_state_t` enum (HOLD, RELEASE, RUN).
- Single flat module: one FSM, one counter, one index register and the output registers. No sub-module is needed.

## Test plan
All scenarios use N_DOM=3, HOLD=16, GAP=8 unless stated.
1. Pulse `arst` → during reset `o_rst_dom`=111, done=0, cause=00. `o_rst_dom` goes 110 at edge 16, 100 at edge 24, 000 with done=1 at edge 32.
2. In RUN, pulse `i_soft_rst_req` at edge E → after E: 111, done=0, cause=01. Releases at E+16, E+24, E+32.
3. In RUN, pulse `i_soft_rst_req` and `i_wdt_expire` at the same edge E → cause=10. Same release timeline as scenario 2.
4. Soft request at E, then watchdog at E+20 (bit 0 already released) → 111 after E+20, cause=10. Releases at E+36, E+44, E+52.
5. Assert `arst` asynchronously at E+28 of a soft sequence → immediately 111, done=0, cause=00. After deassertion, the full 16/24/32 timeline repeats.
6. With N_DOM=1, HOLD=1, GAP=1: after `arst` → `o_rst_dom`=0 and done=1 at edge 1. A soft request at E → `o_rst_dom`=1 at E, released at E+1.
